ball_split_scheduler: RTL
=========================

BALL_SPLIT_SCHEDULER -- requirements
Module: ball_split_scheduler

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, number of ball object slots (power of 2, >=2).
REQ-002 SHALL have parameter MAX_SIZE, default 3, size code of the initial ball; size 0 is the smallest and does not split.
REQ-003 SHALL have parameters INIT_XSPEED, default 64, and INIT_YSPEED, default -128, initial ball speeds (int).
REQ-004 SHALL have port clk, in, 1, the single system clock; all logic on rising edge.
REQ-005 SHALL have port reset, in, 1, synchronous active-high reset.
REQ-006 SHALL have port start_game, in, 1, request to spawn the initial ball.
REQ-007 SHALL have port hit_req, in, 1, a rope or shot hit a ball; held until hit_ack.
REQ-008 SHALL have port hit_slot, in, clog2(NUM_SLOTS), the slot that was hit; stable while hit_req=1.
REQ-009 SHALL have port hit_ack, out, 1, one-cycle pulse that completes the hit transaction.
REQ-010 SHALL have port load_valid, out, 1, one-cycle pulse that loads a ball slot.
REQ-011 SHALL have port load_slot, out, clog2(NUM_SLOTS), target slot of the load or kill.
REQ-012 SHALL have port load_size, out, 2, size code for the loaded ball.
REQ-013 SHALL have ports load_xspeed and load_yspeed, out, int each, speeds for the loaded ball.
REQ-014 SHALL have port kill_valid, out, 1, one-cycle pulse that deactivates load_slot.
REQ-015 SHALL have port slot_active, out, NUM_SLOTS, registered occupancy vector.
REQ-016 SHALL have port all_cleared, out, 1, high when slot_active==0 and the FSM is IDLE after at least one start_game.

Function
REQ-017 SHALL keep an internal table per slot: size, xspeed, yspeed, active.
REQ-018 SHALL implement FSM states IDLE, SEARCH, LOAD1, LOAD2, KILL, ACK.
REQ-019 In IDLE, start_game SHALL load slot 0 next cycle: load_valid=1, size MAX_SIZE, INIT_XSPEED, INIT_YSPEED. It SHALL set slot_active to one-hot bit 0 and stay in IDLE.
REQ-020 start_game SHALL have priority over hit_req in the same IDLE cycle; hit_req stays pending.
REQ-021 start_game outside IDLE SHALL be ignored.
REQ-022 In IDLE, hit_req on an inactive slot SHALL go to ACK with no load or kill.
REQ-023 In IDLE, hit_req on an active slot with size 0 SHALL go to KILL. KILL outputs kill_valid=1, load_slot=hit_slot, clears that active bit, then goes to ACK.
REQ-024 In IDLE, hit_req on an active slot with size>0 SHALL capture the parent's size, xspeed and yspeed, then go to SEARCH with scan index 0.
REQ-025 SEARCH SHALL test one slot per cycle in ascending index order. On the first inactive slot it records it as the free slot and goes to LOAD1. If no inactive slot is found after NUM_SLOTS cycles, it marks child2 dropped and goes to LOAD1.
REQ-026 LOAD1 SHALL load the parent slot with size-1, xspeed=parent x, yspeed=Y, where Y=parent y if parent y<0, else -parent y.
REQ-027 LOAD2 SHALL load the free slot with size-1, xspeed=-parent x, yspeed=Y, and set its active bit. If child2 is dropped, LOAD2 SHALL emit no load_valid.
REQ-028 ACK SHALL pulse hit_ack for exactly one cycle, then return to IDLE.
REQ-029 Hit latency SHALL be: accept cycle T, SEARCH T+1..T+k (k = free index+1, max NUM_SLOTS), LOAD1, LOAD2, ACK.
REQ-030 Negation SHALL be 32-bit two's complement with wrap; -(-2^31) yields -2^31.
REQ-031 Outside their stated states, load_valid, kill_valid and hit_ack SHALL be 0, and the load_* data outputs SHALL hold their last value.
REQ-032 hit_req SHALL be sampled only in IDLE; a request held across ACK is re-accepted as a new hit.

Reset
REQ-033 reset SHALL force IDLE and clear the whole slot table, slot_active, load_valid, kill_valid, hit_ack and all_cleared. It SHALL force load_slot, load_size, load_xspeed and load_yspeed to 0.
REQ-034 reset mid-transaction SHALL abort without an ack or further loads; the first cycle after reset is IDLE.

Verification
REQ-035 Reset, then start_game: next cycle load_valid=1, slot 0, size 3, x=64, y=-128; slot_active=0001.
REQ-036 Hit slot 0 (size 3, x=64, y=50): SEARCH 2 cycles; LOAD1 slot 0 (2, 64, -50); LOAD2 slot 1 (2, -64, -50); hit_ack follows; slot_active=0011.
REQ-037 All 4 slots active; hit slot 2 (size 1): SEARCH 4 cycles; LOAD1 slot 2 size 0; no LOAD2 pulse; hit_ack; slot_active unchanged.
REQ-038 Hit the single active slot 0 with size 0: kill_valid for slot 0, then hit_ack; slot_active=0000; all_cleared=1.
REQ-039 start_game and hit_req together in IDLE: start load first; the hit is serviced afterwards. hit_req on an inactive slot gives hit_ack 1 cycle later with no load.
REQ-040 Assert reset during SEARCH: no hit_ack; all outputs 0 the next cycle; a fresh start_game works normally.

Source files
------------

// File: rtl/ball_split_scheduler.sv
// Ball split scheduler: turns rope/shot hits into slot load/kill commands, splitting a
// hit ball into two smaller children (parent slot reused, sibling placed in a free slot).
module ball_split_scheduler #(
    parameter int NUM_SLOTS   = 4,
    parameter int MAX_SIZE    = 3,
    parameter int INIT_XSPEED = 64,
    parameter int INIT_YSPEED = -128
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_game,
    input  logic                         hit_req,
    input  logic [$clog2(NUM_SLOTS)-1:0] hit_slot,
    output logic                         hit_ack,
    output logic                         load_valid,
    output logic [$clog2(NUM_SLOTS)-1:0] load_slot,
    output logic [1:0]                   load_size,
    output logic signed [31:0]           load_xspeed,
    output logic signed [31:0]           load_yspeed,
    output logic                         kill_valid,
    output logic [NUM_SLOTS-1:0]         slot_active,
    output logic                         all_cleared
);

    localparam int                DATA_W    = 32;
    localparam int                SLOT_W    = $clog2(NUM_SLOTS);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [1:0]        INIT_SIZE = 2'(MAX_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        LOAD1,
        LOAD2,
        KILL,
        ACK
    } state_t;

    state_t state;

    logic [1:0]               tbl_size [NUM_SLOTS];
    logic signed [DATA_W-1:0] tbl_x    [NUM_SLOTS];
    logic signed [DATA_W-1:0] tbl_y    [NUM_SLOTS];

    logic                     started;
    logic [SLOT_W-1:0]        par_slot;
    logic [1:0]               par_size;
    logic signed [DATA_W-1:0] par_x;
    logic signed [DATA_W-1:0] par_y;
    logic [SLOT_W-1:0]        scan_idx;
    logic [SLOT_W-1:0]        free_slot;
    logic                     child2_drop;

    logic [1:0]               child_size;
    logic signed [DATA_W-1:0] child_yspd;
    logic signed [DATA_W-1:0] child2_xspd;

    // Two's complement negation; the most negative value maps onto itself.
    function automatic logic signed [DATA_W-1:0] neg_wrap(input logic signed [DATA_W-1:0] v);
        return -v;
    endfunction

    // Both children always head upward (negative y).
    function automatic logic signed [DATA_W-1:0] child_y(input logic signed [DATA_W-1:0] py);
        return (py < 0) ? py : neg_wrap(py);
    endfunction

    assign child_size  = par_size - 2'd1;
    assign child_yspd  = child_y(par_y);
    assign child2_xspd = neg_wrap(par_x);

    assign all_cleared = started && (state == IDLE) && (slot_active == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            started     <= 1'b0;
            slot_active <= '0;
            load_valid  <= 1'b0;
            kill_valid  <= 1'b0;
            hit_ack     <= 1'b0;
            load_slot   <= '0;
            load_size   <= '0;
            load_xspeed <= '0;
            load_yspeed <= '0;
            par_slot    <= '0;
            par_size    <= '0;
            par_x       <= '0;
            par_y       <= '0;
            scan_idx    <= '0;
            free_slot   <= '0;
            child2_drop <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                tbl_size[i] <= '0;
                tbl_x[i]    <= '0;
                tbl_y[i]    <= '0;
            end
        end else begin
            load_valid <= 1'b0;
            kill_valid <= 1'b0;
            hit_ack    <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (start_game) begin
                        started     <= 1'b1;
                        slot_active <= NUM_SLOTS'(1);
                        tbl_size[0] <= INIT_SIZE;
                        tbl_x[0]    <= INIT_XSPEED;
                        tbl_y[0]    <= INIT_YSPEED;
                        load_valid  <= 1'b1;
                        load_slot   <= '0;
                        load_size   <= INIT_SIZE;
                        load_xspeed <= INIT_XSPEED;
                        load_yspeed <= INIT_YSPEED;
                    end else if (hit_req) begin
                        par_slot <= hit_slot;
                        if (!slot_active[hit_slot]) begin
                            state   <= ACK;
                            hit_ack <= 1'b1;
                        end else if (tbl_size[hit_slot] == 2'd0) begin
                            state                 <= KILL;
                            kill_valid            <= 1'b1;
                            load_slot             <= hit_slot;
                            slot_active[hit_slot] <= 1'b0;
                        end else begin
                            state       <= SEARCH;
                            par_size    <= tbl_size[hit_slot];
                            par_x       <= tbl_x[hit_slot];
                            par_y       <= tbl_y[hit_slot];
                            scan_idx    <= '0;
                            child2_drop <= 1'b0;
                        end
                    end
                end

                // One slot per cycle; an exhausted scan drops the second child.
                SEARCH: begin
                    if (!slot_active[scan_idx] || scan_idx == LAST_SLOT) begin
                        state              <= LOAD1;
                        free_slot          <= scan_idx;
                        child2_drop        <= slot_active[scan_idx];
                        load_valid         <= 1'b1;
                        load_slot          <= par_slot;
                        load_size          <= child_size;
                        load_xspeed        <= par_x;
                        load_yspeed        <= child_yspd;
                        tbl_size[par_slot] <= child_size;
                        tbl_y[par_slot]    <= child_yspd;
                    end else begin
                        scan_idx <= scan_idx + SLOT_W'(1);
                    end
                end

                LOAD1: begin
                    state <= LOAD2;
                    if (!child2_drop) begin
                        load_valid             <= 1'b1;
                        load_slot              <= free_slot;
                        load_size              <= child_size;
                        load_xspeed            <= child2_xspd;
                        load_yspeed            <= child_yspd;
                        slot_active[free_slot] <= 1'b1;
                        tbl_size[free_slot]    <= child_size;
                        tbl_x[free_slot]       <= child2_xspd;
                        tbl_y[free_slot]       <= child_yspd;
                    end
                end

                LOAD2: begin
                    state   <= ACK;
                    hit_ack <= 1'b1;
                end

                KILL: begin
                    state   <= ACK;
                    hit_ack <= 1'b1;
                end

                ACK: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
